// File: rtl/matmul_ctrl_pkg.sv
// Shared types for the matrix-multiplication phase controller.
// The status encoding is also the FSM state encoding, so status is the state register itself.
package matmul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Width of the phase index; a single-phase build still needs one bit.
    function automatic int unsigned phase_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_phase_controller_start_qualifier.sv
// Start qualifier: counts held-start cycles while arming and tracks the
// rearm flag that forces start to be seen low before another run.
module matmul_phase_controller_start_qualifier #(
    parameter int unsigned START_HOLD = 10
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic arm_i,
    input  logic rearm_clr_i,
    output logic hold_met_o,
    output logic rearm_o
);

    localparam int unsigned CW = $clog2(START_HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rearm_q, rearm_d;

    assign hold_met_o = arm_i && start_i && (cnt_q == CW'(START_HOLD - 1));
    assign rearm_o    = rearm_q;

    // Counter runs only in ARM with start held, so it is always zero on ARM entry;
    // a low start always rearms, even on the cycle a clear is requested.
    always_comb begin
        cnt_d   = '0;
        rearm_d = rearm_q;
        if (arm_i && start_i && !hold_met_o) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (!start_i) begin
            rearm_d = 1'b1;
        end else if (rearm_clr_i) begin
            rearm_d = 1'b0;
        end
    end

    // Hold counter and rearm flag registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            rearm_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            rearm_q <= rearm_d;
        end
    end

endmodule

// File: rtl/matmul_phase_controller.sv
// Phase sequencer for the matmul datapath: qualifies start, pulses the
// datapath reset for START_HOLD cycles, then walks one-hot phase enables.
//
// state | meaning
// IDLE  | waiting for a qualified start (start high and rearmed)
// ARM   | dp_rst asserted while start is held for START_HOLD cycles
// RUN   | phase_en one-hot on the active phase, advanced by phase_done
// DONE  | last phase finished; waits for abort or a fresh start edge
//
// Optional build macro MATMUL_PHASE_TIMEOUT_EN adds a per-phase watchdog that
// aborts a stalled RUN to IDLE and raises timeout_err until the next ARM.
module matmul_phase_controller
    import matmul_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PHASES  = 3,
    parameter int unsigned START_HOLD  = 10,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned PW = phase_width(NUM_PHASES)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  phase_done_i,
    input  logic                  abort_i,
    output logic [1:0]            status_o,
    output logic [PW-1:0]         phase_o,
    output logic                  dp_rst_o,
    output logic [NUM_PHASES-1:0] phase_en_o,
    output logic [NUM_PHASES-1:0] phase_seen_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_err_o
);

    localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

    state_t                  state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [NUM_PHASES-1:0]   seen_q, seen_d;
    logic                    done_q, done_d;
    logic                    hold_met;
    logic                    rearm;
    logic                    rearm_clr;
    logic                    arm_entry;
    logic                    timeout_hit;

    matmul_phase_controller_start_qualifier #(
        .START_HOLD (START_HOLD)
    ) u_start_qual (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .arm_i       (state_q == ST_ARM),
        .rearm_clr_i (rearm_clr),
        .hold_met_o  (hold_met),
        .rearm_o     (rearm)
    );

`ifdef MATMUL_PHASE_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          terr_q, terr_d;

    assign timeout_hit   = (state_q == ST_RUN) && (wd_q == WW'(TIMEOUT_CYC - 1));
    assign timeout_err_o = terr_q;

    // Watchdog counts RUN cycles without a phase advance; the error is sticky until ARM.
    always_comb begin
        wd_d   = '0;
        terr_d = terr_q;
        if (state_q == ST_RUN && !phase_done_i) begin
            wd_d = wd_q + 1'b1;
        end
        if (arm_entry) begin
            terr_d = 1'b0;
        end else if (state_q == ST_RUN && !abort_i && timeout_hit) begin
            terr_d = 1'b1;
        end
    end

    // Watchdog and sticky error registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    // Next state and phase; abort outranks timeout, which outranks phase_done.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && rearm) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort_i || !start_i) begin
                    state_d = ST_IDLE;
                end else if (hold_met) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_i || timeout_hit) begin
                    state_d = ST_IDLE;
                end else if (phase_done_i) begin
                    if (phase_q == LAST_PHASE) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (start_i && rearm) begin
                    state_d = ST_ARM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Phase index is only meaningful in RUN/DONE; it restarts from 0 otherwise.
        if (state_d == ST_IDLE || state_d == ST_ARM) begin
            phase_d = '0;
        end
    end

    assign arm_entry = (state_d == ST_ARM) && (state_q != ST_ARM);
    assign rearm_clr = (state_d != state_q) && (state_d == ST_DONE || state_d == ST_IDLE);

    // Sticky visited flags follow the phase being entered, and done marks DONE entry.
    always_comb begin
        seen_d = seen_q;
        if (arm_entry) begin
            seen_d = '0;
        end
        if (state_d == ST_RUN) begin
            seen_d = seen_d | (NUM_PHASES'(1) << phase_d);
        end
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Controller state registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            seen_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            seen_q  <= seen_d;
            done_q  <= done_d;
        end
    end

    assign status_o     = state_q;
    assign phase_o      = phase_q;
    assign dp_rst_o     = (state_q == ST_ARM);
    assign busy_o       = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign phase_en_o   = (state_q == ST_RUN) ? (NUM_PHASES'(1) << phase_q) : '0;
    assign phase_seen_o = seen_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_matmul_phase_controller.sv
// Scoreboard bench for matmul_phase_controller (3 phases, 10-cycle hold, 16-cycle watchdog).
module tb_matmul_phase_controller;

    logic       clock;
    logic       reset;
    logic       start;
    logic       phase_done;
    logic       abort;
    logic [1:0] status;
    logic [1:0] phase;
    logic       dp_rst;
    logic [2:0] phase_en;
    logic [2:0] phase_seen;
    logic       busy;
    logic       done;
    logic       timeout_err;

    matmul_phase_controller #(
        .NUM_PHASES  (3),
        .START_HOLD  (10),
        .TIMEOUT_CYC (16)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .start_i       (start),
        .phase_done_i  (phase_done),
        .abort_i       (abort),
        .status_o      (status),
        .phase_o       (phase),
        .dp_rst_o      (dp_rst),
        .phase_en_o    (phase_en),
        .phase_seen_o  (phase_seen),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_err_o (timeout_err)
    );

    typedef struct {
        int          at;
        string       name;
        logic [13:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // {status, phase, dp_rst, phase_en, phase_seen, busy, done, timeout_err}
    function automatic logic [13:0] mk(input logic [1:0] st, input logic [1:0] ph, input logic dp,
                                       input logic [2:0] en, input logic [2:0] seen,
                                       input logic bz, input logic dn, input logic te);
        return {st, ph, dp, en, seen, bz, dn, te};
    endfunction

    function automatic logic [13:0] v_idle(input logic [2:0] seen, input logic te);
        return mk(2'b00, 2'd0, 1'b0, 3'b000, seen, 1'b0, 1'b0, te);
    endfunction

    function automatic logic [13:0] v_arm();
        return mk(2'b01, 2'd0, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [13:0] v_run(input logic [1:0] ph, input logic [2:0] en, input logic [2:0] seen);
        return mk(2'b10, ph, 1'b0, en, seen, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [13:0] v_done(input logic dn);
        return mk(2'b11, 2'd2, 1'b0, 3'b000, 3'b111, 1'b0, dn, 1'b0);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic exp_at(input int d, input string nm, input logic [13:0] v);
        exp_t e;
        e.at   = cyc + d;
        e.name = nm;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    // Monitor: compare scheduled snapshots and every done pulse against the scoreboard.
    always @(negedge clock) begin
        logic [13:0] got;
        exp_t        e;
        got = {status, phase, dp_rst, phase_en, phase_seen, busy, done, timeout_err};
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.at != cyc) begin
                n_fail++;
                $display("FAIL %s: checked late at cycle %0d, scheduled %0d", e.name, cyc, e.at);
            end else if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s: cycle %0d got %b expected %b (st,ph,dp,en,seen,busy,done,terr)",
                         e.name, cyc, got, e.v);
            end
        end
        if (done === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_pulse: unexpected done at cycle %0d, none expected", cyc);
            end else if (done_q[0] != cyc) begin
                n_fail++;
                $display("FAIL done_pulse: done at cycle %0d expected at cycle %0d", cyc, done_q[0]);
                void'(done_q.pop_front());
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 1000", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        phase_done = 1'b0;
        abort      = 1'b0;
        tick(1);
        exp_at(0, "reset_hold", v_idle(3'b000, 1'b0));
        tick(1);
        reset = 1'b0;
        exp_at(1, "post_reset", v_idle(3'b000, 1'b0));
        tick(1);

        // Start held only 6 cycles: arms, then falls back without running.
        start = 1'b1;
        exp_at(0, "b_idle_before", v_idle(3'b000, 1'b0));
        exp_at(1, "b_arm_entry", v_arm());
        exp_at(6, "b_arm_6", v_arm());
        tick(6);
        start = 1'b0;
        exp_at(1, "b_back_idle", v_idle(3'b000, 1'b0));
        exp_at(2, "b_stay_idle", v_idle(3'b000, 1'b0));
        tick(2);

        // Full hold: dp_rst high for exactly 10 cycles, then RUN phase 0.
        start = 1'b1;
        exp_at(0, "a_idle_before", v_idle(3'b000, 1'b0));
        exp_at(1, "a_arm_first", v_arm());
        exp_at(10, "a_arm_last", v_arm());
        exp_at(11, "a_run_entry", v_run(2'd0, 3'b001, 3'b001));
        tick(11);

        // Three phase_done pulses 5 cycles apart; start stays high and is ignored.
        exp_at(2, "c_ph0_hold", v_run(2'd0, 3'b001, 3'b001));
        tick(2);
        phase_done = 1'b1;
        exp_at(1, "c_ph1", v_run(2'd1, 3'b010, 3'b011));
        tick(1);
        phase_done = 1'b0;
        exp_at(4, "c_ph1_hold", v_run(2'd1, 3'b010, 3'b011));
        tick(4);
        phase_done = 1'b1;
        exp_at(1, "c_ph2", v_run(2'd2, 3'b100, 3'b111));
        tick(1);
        phase_done = 1'b0;
        tick(4);
        phase_done = 1'b1;
        exp_at(1, "c_done_entry", v_done(1'b1));
        done_q.push_back(cyc + 1);
        exp_at(2, "c_done_second", v_done(1'b0));
        tick(1);
        phase_done = 1'b0;
        tick(1);

        // DONE holds while start stays high; a low-then-high start re-arms.
        exp_at(20, "d_hold_20", v_done(1'b0));
        tick(20);
        start = 1'b0;
        exp_at(1, "d_start_low", v_done(1'b0));
        tick(1);
        start = 1'b1;
        exp_at(1, "d_rearm", v_arm());
        tick(1);

        // Abort together with phase_done in phase 1.
        exp_at(10, "e_run_entry", v_run(2'd0, 3'b001, 3'b001));
        tick(10);
        phase_done = 1'b1;
        exp_at(1, "e_ph1", v_run(2'd1, 3'b010, 3'b011));
        tick(1);
        phase_done = 1'b0;
        tick(2);
        abort      = 1'b1;
        phase_done = 1'b1;
        exp_at(1, "e_abort", v_idle(3'b011, 1'b0));
        tick(1);
        abort      = 1'b0;
        exp_at(1, "e_no_rearm", v_idle(3'b011, 1'b0));
        tick(1);
        phase_done = 1'b0;

        // Reset in the middle of ARM, then rearm is set again by reset.
        start = 1'b0;
        exp_at(1, "f_idle", v_idle(3'b011, 1'b0));
        tick(1);
        start = 1'b1;
        exp_at(1, "f_arm", v_arm());
        tick(3);
        reset = 1'b1;
        exp_at(1, "f_reset_mid_arm", v_idle(3'b000, 1'b0));
        tick(1);
        reset = 1'b0;
        exp_at(1, "f_arm_after_reset", v_arm());
        tick(1);
        start = 1'b0;
        exp_at(1, "f_idle_final", v_idle(3'b000, 1'b0));
        tick(1);

`ifdef MATMUL_PHASE_TIMEOUT_EN
        // No phase_done for 16 RUN cycles: watchdog drops to IDLE with a sticky error.
        start = 1'b1;
        exp_at(11, "g_run_entry", v_run(2'd0, 3'b001, 3'b001));
        exp_at(26, "g_last_run", v_run(2'd0, 3'b001, 3'b001));
        exp_at(27, "g_timeout", v_idle(3'b001, 1'b1));
        tick(27);
        exp_at(1, "g_err_sticky", v_idle(3'b001, 1'b1));
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        exp_at(1, "g_arm_clears_err", v_arm());
        tick(1);
        start = 1'b0;
        exp_at(1, "g_idle_final", v_idle(3'b000, 1'b0));
        tick(1);
`endif

        tick(2);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, scheduled cycle %0d, final cycle %0d", e.name, e.at, cyc);
        end
        while (done_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_pulse: missing done, expected at cycle %0d got none", done_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
